// File: rtl/simon_pipeline_cfg.sv
// Fully unrolled Simon datapath, one round per stage, with valid/ready flow control.
// Define SIMON_DECRYPT_EN to build the per-beat decrypt path (mode registers and key muxes).
module simon_pipeline_cfg #(
    parameter int unsigned N     = 16,
    parameter int unsigned T     = 32,
    parameter int unsigned TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2*N-1:0]   in_block,
    input  logic             in_decrypt,
    input  logic [TAG_W-1:0] in_tag,
    input  logic [T*N-1:0]   round_keys,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*N-1:0]   out_block,
    output logic             out_decrypt,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    function automatic logic [N-1:0] rotl(input logic [N-1:0] v, input int unsigned r);
        logic [2*N-1:0] d;
        d = {v, v} << (r % N);
        return d[2*N-1:N];
    endfunction

    function automatic logic [N-1:0] simon_f(input logic [N-1:0] v);
        return (rotl(v, 1) & rotl(v, 8)) ^ rotl(v, 2);
    endfunction

    logic [N-1:0]     x_q   [T];
    logic [N-1:0]     y_q   [T];
    logic             v_q   [T];
    logic [TAG_W-1:0] tag_q [T];
`ifdef SIMON_DECRYPT_EN
    logic             dec_q [T];
`else
    logic             unused_in_decrypt;
    assign unused_in_decrypt = in_decrypt;
`endif

    // Single global enable: the whole pipe moves or the whole pipe holds.
    logic adv;
    assign adv      = !(v_q[T-1] && !out_ready);
    assign in_ready = adv;

    for (genvar s = 0; s < T; s++) begin : g_stage
        logic [N-1:0]     src_x;
        logic [N-1:0]     src_y;
        logic             src_v;
        logic [TAG_W-1:0] src_tag;
        logic [N-1:0]     key;
        logic [N-1:0]     rx;
        logic [N-1:0]     nxt_x;
        logic [N-1:0]     nxt_y;
`ifdef SIMON_DECRYPT_EN
        logic             src_dec;
`endif

        if (s == 0) begin : g_src
            assign src_v   = in_valid;
            assign src_tag = in_tag;
`ifdef SIMON_DECRYPT_EN
            // Decrypt runs the forward round on word-swapped state.
            assign src_dec = in_decrypt;
            assign src_x   = in_decrypt ? in_block[N-1:0]   : in_block[2*N-1:N];
            assign src_y   = in_decrypt ? in_block[2*N-1:N] : in_block[N-1:0];
`else
            assign src_x   = in_block[2*N-1:N];
            assign src_y   = in_block[N-1:0];
`endif
        end else begin : g_src
            assign src_v   = v_q[s-1];
            assign src_tag = tag_q[s-1];
            assign src_x   = x_q[s-1];
            assign src_y   = y_q[s-1];
`ifdef SIMON_DECRYPT_EN
            assign src_dec = dec_q[s-1];
`endif
        end

`ifdef SIMON_DECRYPT_EN
        assign key = src_dec ? round_keys[(T-1-s)*N +: N] : round_keys[s*N +: N];
`else
        assign key = round_keys[s*N +: N];
`endif

        assign rx = src_y ^ simon_f(src_x) ^ key;

`ifdef SIMON_DECRYPT_EN
        if (s == T - 1) begin : g_last
            // Undo the input swap so the output uses the normal x/y packing.
            assign nxt_x = src_dec ? src_x : rx;
            assign nxt_y = src_dec ? rx    : src_x;
        end else begin : g_mid
            assign nxt_x = rx;
            assign nxt_y = src_x;
        end
`else
        assign nxt_x = rx;
        assign nxt_y = src_x;
`endif

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                x_q[s]   <= '0;
                y_q[s]   <= '0;
                v_q[s]   <= 1'b0;
                tag_q[s] <= '0;
`ifdef SIMON_DECRYPT_EN
                dec_q[s] <= 1'b0;
`endif
            end else if (adv) begin
                x_q[s]   <= nxt_x;
                y_q[s]   <= nxt_y;
                v_q[s]   <= src_v;
                tag_q[s] <= src_tag;
`ifdef SIMON_DECRYPT_EN
                dec_q[s] <= src_dec;
`endif
            end
        end
    end

    assign out_valid = v_q[T-1];
    assign out_block = {x_q[T-1], y_q[T-1]};
    assign out_tag   = tag_q[T-1];
`ifdef SIMON_DECRYPT_EN
    assign out_decrypt = dec_q[T-1];
`else
    assign out_decrypt = 1'b0;
`endif

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < T; i++) begin
            busy = busy | v_q[i];
        end
    end

endmodule

// File: tb/tb_simon_pipeline_cfg.sv
// Self-checking bench for simon_pipeline_cfg (N=16, T=32); reference Simon model inside.
// Honours SIMON_DECRYPT_EN: decrypt beats are only expected when it is defined.
module tb_simon_pipeline_cfg;

    localparam int N     = 16;
    localparam int T     = 32;
    localparam int TAG_W = 4;
`ifdef SIMON_DECRYPT_EN
    localparam bit DEC_EN = 1'b1;
`else
    localparam bit DEC_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [2*N-1:0]   in_block;
    logic             in_decrypt;
    logic [TAG_W-1:0] in_tag;
    logic [T*N-1:0]   round_keys;
    logic             out_valid;
    logic             out_ready;
    logic [2*N-1:0]   out_block;
    logic             out_decrypt;
    logic [TAG_W-1:0] out_tag;
    logic             busy;

    simon_pipeline_cfg #(.N(N), .T(T), .TAG_W(TAG_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_block    (in_block),
        .in_decrypt  (in_decrypt),
        .in_tag      (in_tag),
        .round_keys  (round_keys),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_block   (out_block),
        .out_decrypt (out_decrypt),
        .out_tag     (out_tag),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [2*N-1:0]   blk;
        logic             dec;
        logic [TAG_W-1:0] tag;
        int               cyc;
    } beat_t;

    beat_t exp_q[$];
    beat_t obs_q[$];
    beat_t e_b;
    beat_t o_b;

    // Reference Simon, plain word arithmetic.
    function automatic logic [15:0] rol(input logic [15:0] v, input int r);
        return (v << r) | (v >> (16 - r));
    endfunction

    function automatic logic [15:0] ror(input logic [15:0] v, input int r);
        return (v >> r) | (v << (16 - r));
    endfunction

    function automatic logic [15:0] ff(input logic [15:0] v);
        return (rol(v, 1) & rol(v, 8)) ^ rol(v, 2);
    endfunction

    function automatic logic [31:0] model_enc(input logic [31:0] p, input logic [T*N-1:0] rk);
        logic [15:0] x, y, t;
        x = p[31:16];
        y = p[15:0];
        for (int i = 0; i < T; i++) begin
            t = x;
            x = y ^ ff(x) ^ rk[i*N +: N];
            y = t;
        end
        return {x, y};
    endfunction

    function automatic logic [31:0] model_dec(input logic [31:0] c, input logic [T*N-1:0] rk);
        logic [15:0] x, y, t;
        x = c[31:16];
        y = c[15:0];
        for (int i = T - 1; i >= 0; i--) begin
            t = y;
            y = x ^ ff(y) ^ rk[i*N +: N];
            x = t;
        end
        return {x, y};
    endfunction

    // Simon32/64 key expansion of 0x1918111009080100.
    function automatic logic [T*N-1:0] kat_keys();
        logic [61:0]    z;
        logic [15:0]    k [T];
        logic [15:0]    tmp;
        logic [T*N-1:0] rk;
        z = 62'b11111010001001010110000111001101111101000100101011000011100110;
        k[0] = 16'h0100;
        k[1] = 16'h0908;
        k[2] = 16'h1110;
        k[3] = 16'h1918;
        for (int i = 4; i < T; i++) begin
            tmp  = ror(k[i-1], 3) ^ k[i-3];
            tmp  = tmp ^ ror(tmp, 1);
            k[i] = k[i-4] ^ tmp ^ {15'd0, z[61 - ((i - 4) % 62)]} ^ 16'hfffc;
        end
        for (int i = 0; i < T; i++) rk[i*N +: N] = k[i];
        return rk;
    endfunction

    function automatic logic [T*N-1:0] rand_keys();
        logic [T*N-1:0] rk;
        for (int i = 0; i < T; i++) rk[i*N +: N] = 16'($urandom);
        return rk;
    endfunction

    // Scoreboard collector: records accepted beats (with model result) and consumed results.
    always @(negedge clk) begin
        if (!rst) begin
            if (in_valid && in_ready) begin
                e_b.dec = DEC_EN ? in_decrypt : 1'b0;
                e_b.blk = e_b.dec ? model_dec(in_block, round_keys)
                                  : model_enc(in_block, round_keys);
                e_b.tag = in_tag;
                e_b.cyc = cyc;
                exp_q.push_back(e_b);
            end
            if (out_valid && out_ready) begin
                o_b.blk = out_block;
                o_b.dec = out_decrypt;
                o_b.tag = out_tag;
                o_b.cyc = cyc;
                obs_q.push_back(o_b);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_outputs(input int n, input int budget);
        for (int i = 0; i < budget && obs_q.size() < n; i++) tick();
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && busy; i++) tick();
        tick();
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_block   = '0;
        in_decrypt = 1'b0;
        in_tag     = '0;
        out_ready  = 1'b1;
        round_keys = kat_keys();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid);
        end
        total++;
        if (out_block !== 32'h0) begin
            bad++; $display("FAIL reset_out_block got=%h want=0", out_block);
        end
        total++;
        if (out_tag !== 4'h0) begin
            bad++; $display("FAIL reset_out_tag got=%h want=0", out_tag);
        end
        total++;
        if (out_decrypt !== 1'b0) begin
            bad++; $display("FAIL reset_out_decrypt got=%b want=0", out_decrypt);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL reset_busy got=%b want=0", busy);
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready);
        end
        tick();
    endtask

    task automatic run_kat(input string name, input logic [31:0] blk, input logic dec,
                           input logic [31:0] want);
        wait_idle();
        round_keys = kat_keys();
        in_valid   = 1'b1;
        in_block   = blk;
        in_decrypt = dec;
        in_tag     = 4'h3;
        tick();
        in_valid = 1'b0;
        wait_outputs(1, 60);
        total++;
        if (obs_q.size() != 1 || exp_q.size() != 1) begin
            bad++;
            $display("FAIL %s_count got=%0d want=1", name, obs_q.size());
        end else begin
            total++;
            if (obs_q[0].blk !== want) begin
                bad++; $display("FAIL %s_block got=%h want=%h", name, obs_q[0].blk, want);
            end
            total++;
            if (obs_q[0].tag !== 4'h3 || obs_q[0].dec !== dec) begin
                bad++;
                $display("FAIL %s_tag_mode got=%h/%b want=3/%b", name, obs_q[0].tag,
                         obs_q[0].dec, dec);
            end
            total++;
            if (obs_q[0].cyc - exp_q[0].cyc != T) begin
                bad++;
                $display("FAIL %s_latency got=%0d want=%0d", name,
                         obs_q[0].cyc - exp_q[0].cyc, T);
            end
        end
    endtask

    task automatic test_kat_encrypt();
        run_kat("kat_enc", 32'h65656877, 1'b0, 32'hc69be9bb);
    endtask

    task automatic test_kat_decrypt();
        run_kat("kat_dec", 32'hc69be9bb, 1'b1, 32'h65656877);
    endtask

    task automatic test_stream();
        int not_ready;
        not_ready = 0;
        wait_idle();
        round_keys = rand_keys();
        out_ready  = 1'b1;
        for (int i = 0; i < 64; i++) begin
            in_valid   = 1'b1;
            in_block   = $urandom;
            in_decrypt = 1'($urandom);
            in_tag     = 4'($urandom);
            if (!in_ready) not_ready++;
            tick();
        end
        in_valid = 1'b0;
        wait_outputs(64, 200);
        total++;
        if (not_ready != 0) begin
            bad++; $display("FAIL stream_in_ready drops got=%0d want=0", not_ready);
        end
        total++;
        if (obs_q.size() != 64 || exp_q.size() != 64) begin
            bad++;
            $display("FAIL stream_count got=%0d/%0d want=64", obs_q.size(), exp_q.size());
        end else begin
            total++;
            if (obs_q[0].cyc - exp_q[0].cyc != T) begin
                bad++;
                $display("FAIL stream_latency got=%0d want=%0d", obs_q[0].cyc - exp_q[0].cyc, T);
            end
            for (int i = 0; i < 64; i++) begin
                total++;
                if (obs_q[i].blk !== exp_q[i].blk || obs_q[i].tag !== exp_q[i].tag ||
                    obs_q[i].dec !== exp_q[i].dec || obs_q[i].cyc != obs_q[0].cyc + i) begin
                    bad++;
                    $display("FAIL stream_beat%0d got=%h/%h/%b@%0d want=%h/%h/%b@%0d", i,
                             obs_q[i].blk, obs_q[i].tag, obs_q[i].dec, obs_q[i].cyc,
                             exp_q[i].blk, exp_q[i].tag, exp_q[i].dec, obs_q[0].cyc + i);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] bb [40];
        logic        bd [40];
        logic [3:0]  bt [40];
        logic [31:0] snap_blk;
        logic [3:0]  snap_tag;
        int          stall_left;
        int          j;
        wait_idle();
        round_keys = rand_keys();
        for (int i = 0; i < 40; i++) begin
            bb[i] = $urandom;
            bd[i] = 1'($urandom);
            bt[i] = 4'($urandom);
        end
        stall_left = -1;
        snap_blk   = '0;
        snap_tag   = '0;
        for (int c = 0; c < 300; c++) begin
            j = exp_q.size();
            if (j < 40) begin
                in_valid   = 1'b1;
                in_block   = bb[j];
                in_decrypt = bd[j];
                in_tag     = bt[j];
            end else begin
                in_valid = 1'b0;
            end
            if (stall_left < 0 && out_valid) begin
                stall_left = 5;
                out_ready  = 1'b0;
                snap_blk   = out_block;
                snap_tag   = out_tag;
            end else if (stall_left > 0) begin
                total++;
                if (out_valid !== 1'b1 || out_block !== snap_blk || out_tag !== snap_tag) begin
                    bad++;
                    $display("FAIL bp_frozen got=%b/%h/%h want=1/%h/%h", out_valid, out_block,
                             out_tag, snap_blk, snap_tag);
                end
                total++;
                if (in_ready !== 1'b0) begin
                    bad++; $display("FAIL bp_in_ready got=%b want=0", in_ready);
                end
                stall_left--;
                if (stall_left == 0) out_ready = 1'b1;
            end
            if (j >= 40 && stall_left == 0) break;
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_outputs(40, 200);
        total++;
        if (obs_q.size() != 40 || exp_q.size() != 40 || stall_left != 0) begin
            bad++;
            $display("FAIL bp_count got=%0d/%0d stall=%0d want=40/40 stall=0", obs_q.size(),
                     exp_q.size(), stall_left);
        end else begin
            for (int i = 0; i < 40; i++) begin
                total++;
                if (obs_q[i].blk !== exp_q[i].blk || obs_q[i].tag !== exp_q[i].tag ||
                    obs_q[i].dec !== exp_q[i].dec) begin
                    bad++;
                    $display("FAIL bp_beat%0d got=%h/%h/%b want=%h/%h/%b", i, obs_q[i].blk,
                             obs_q[i].tag, obs_q[i].dec, exp_q[i].blk, exp_q[i].tag,
                             exp_q[i].dec);
                end
            end
        end
    endtask

    task automatic test_bubbles();
        int fall;
        int last;
        wait_idle();
        round_keys = rand_keys();
        for (int i = 0; i < 16; i++) begin
            in_valid   = (i % 2 == 0);
            in_block   = $urandom;
            in_decrypt = 1'($urandom);
            in_tag     = 4'($urandom);
            tick();
        end
        in_valid = 1'b0;
        fall = -1;
        for (int i = 0; i < 100 && fall < 0; i++) begin
            tick();
            if (!busy) fall = cyc;
        end
        total++;
        if (obs_q.size() != 8 || exp_q.size() != 8) begin
            bad++;
            $display("FAIL bubble_count got=%0d/%0d want=8", obs_q.size(), exp_q.size());
        end else begin
            last = exp_q[7].cyc;
            for (int i = 0; i < 8; i++) begin
                total++;
                if (obs_q[i].blk !== exp_q[i].blk || obs_q[i].tag !== exp_q[i].tag ||
                    obs_q[i].cyc != exp_q[i].cyc + T || exp_q[i].cyc != exp_q[0].cyc + 2 * i) begin
                    bad++;
                    $display("FAIL bubble_beat%0d got=%h/%h@%0d want=%h/%h@%0d", i,
                             obs_q[i].blk, obs_q[i].tag, obs_q[i].cyc, exp_q[i].blk,
                             exp_q[i].tag, exp_q[i].cyc + T);
                end
            end
            // Last beat sits in the final stage at last+T and leaves on the next edge.
            total++;
            if (fall != last + T + 1) begin
                bad++; $display("FAIL bubble_busy_fall got=%0d want=%0d", fall, last + T + 1);
            end
        end
    endtask

    task automatic test_reset_midflight();
        wait_idle();
        round_keys = rand_keys();
        for (int i = 0; i < 10; i++) begin
            in_valid   = 1'b1;
            in_block   = $urandom;
            in_decrypt = 1'($urandom);
            in_tag     = 4'($urandom);
            tick();
        end
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (out_valid !== 1'b0 || out_block !== 32'h0 || out_tag !== 4'h0 ||
            out_decrypt !== 1'b0) begin
            bad++;
            $display("FAIL midrst_outputs got=%b/%h/%h/%b want=0/0/0/0", out_valid, out_block,
                     out_tag, out_decrypt);
        end
        total++;
        if (busy !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL midrst_busy_ready got=%b/%b want=0/1", busy, in_ready);
        end
        tick();
        rst = 1'b0;
        exp_q.delete();
        obs_q.delete();
        repeat (40) tick();
        total++;
        if (obs_q.size() != 0) begin
            bad++; $display("FAIL midrst_ghost got=%0d want=0", obs_q.size());
        end
        in_valid   = 1'b1;
        in_block   = $urandom;
        in_decrypt = 1'($urandom);
        in_tag     = 4'($urandom);
        tick();
        in_valid = 1'b0;
        wait_outputs(1, 60);
        total++;
        if (obs_q.size() != 1 || exp_q.size() != 1) begin
            bad++; $display("FAIL midrst_next_count got=%0d want=1", obs_q.size());
        end else begin
            total++;
            if (obs_q[0].blk !== exp_q[0].blk || obs_q[0].tag !== exp_q[0].tag ||
                obs_q[0].dec !== exp_q[0].dec || obs_q[0].cyc - exp_q[0].cyc != T) begin
                bad++;
                $display("FAIL midrst_next got=%h/%h/%b@%0d want=%h/%h/%b@%0d", obs_q[0].blk,
                         obs_q[0].tag, obs_q[0].dec, obs_q[0].cyc, exp_q[0].blk, exp_q[0].tag,
                         exp_q[0].dec, exp_q[0].cyc + T);
            end
        end
    endtask

    initial begin
        test_reset();
        test_kat_encrypt();
        if (DEC_EN) test_kat_decrypt();
        test_stream();
        test_backpressure();
        test_bubbles();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
